// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// default latencies, FSM state encoding and the multicycle-op decoder.
// Optional feature macro: MDU_MADD_EN (op 7 = signed MADD into HI/LO).
package mdu_sched_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_MADD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W           = 4;

    // Ops that occupy the unit for a counted latency; op 7 only when MADD exists.
    function automatic logic is_multicycle(input md_op_e op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD:                            return 1'b1;
`endif
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// Execute-stage <-> multiply/divide unit bundle. The master side is the
// pipeline (issue, operands, D-stage usage); the slave side is mdu_sched.
interface mdu_sched_if;
    import mdu_sched_pkg::*;

    logic        start;
    md_op_e      op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        d_uses_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    modport master (
        output start, op, d1, d2, d_uses_md,
        input  hi, lo, busy, stall, done
    );

    modport slave (
        input  start, op, d1, d2, d_uses_md,
        output hi, lo, busy, stall, done
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational product / quotient / remainder generator. Produces the
// {hi,lo} value to be latched as the pending result at issue time.
// With MDU_MADD_EN defined, op 7 adds the signed product to the current HI/LO.
module mdu_arith
    import mdu_sched_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] d1_i,
    input  logic [31:0] d2_i,
    input  logic [31:0] acc_hi_i,
    input  logic [31:0] acc_lo_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o
);

    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic               div_zero;
    logic               s_ovf;
    logic        [31:0] s_div;
    logic        [31:0] u_div;
    logic        [31:0] s_quot;
    logic        [31:0] s_rem;
    logic        [31:0] u_quot;
    logic        [31:0] u_rem;

    assign s_prod = $signed({{32{d1_i[31]}}, d1_i}) * $signed({{32{d2_i[31]}}, d2_i});
    assign u_prod = {32'd0, d1_i} * {32'd0, d2_i};

    // A zero divisor never reaches the dividers, and the single signed
    // overflow case (-2^31 / -1) is divided by 1 instead, which yields
    // exactly the wrapped quotient 0x80000000 with remainder 0.
    assign div_zero = (d2_i == 32'd0);
    assign s_ovf    = (d1_i == 32'h8000_0000) && (d2_i == 32'hFFFF_FFFF);
    assign s_div    = (div_zero || s_ovf) ? 32'd1 : d2_i;
    assign u_div    = div_zero ? 32'd1 : d2_i;

    assign s_quot = $signed(d1_i) / $signed(s_div);
    assign s_rem  = $signed(d1_i) % $signed(s_div);
    assign u_quot = d1_i / u_div;
    assign u_rem  = d1_i % u_div;

    // Select the result for the issued op; anything else (incl. /0) keeps HI/LO.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        res_hi_o = acc_hi_i;
        res_lo_o = acc_lo_i;
        case (op_i)
            MD_MULT:  {res_hi_o, res_lo_o} = $unsigned(s_prod);
            MD_MULTU: {res_hi_o, res_lo_o} = u_prod;
            MD_DIV: begin
                if (!div_zero) begin
                    res_hi_o = s_rem;
                    res_lo_o = s_quot;
                end
            end
            MD_DIVU: begin
                if (!div_zero) begin
                    res_hi_o = u_rem;
                    res_lo_o = u_quot;
                end
            end
`ifdef MDU_MADD_EN
            MD_MADD:  {res_hi_o, res_lo_o} = {acc_hi_i, acc_lo_i} + $unsigned(s_prod);
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// E-stage multiply/divide sequencer: latches the result at issue, counts the
// fixed latency, commits HI/LO with a one-cycle done pulse, and drives busy
// and the D-stage stall. Optional feature macro: MDU_MADD_EN.
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    mdu_sched_if.slave  md
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             done_q, done_d;
    logic [31:0]      res_hi, res_lo;
    logic             issue_mc;
    logic             busy;

    mdu_arith u_arith (
        .op_i     (md.op),
        .d1_i     (md.d1),
        .d2_i     (md.d2),
        .acc_hi_i (hi_q),
        .acc_lo_i (lo_q),
        .res_hi_o (res_hi),
        .res_lo_o (res_lo)
    );

    assign issue_mc = md.start && is_multicycle(md.op);

    // Next-state: issue in IDLE, count down in RUN, commit at zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_mc) begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    cnt_d     = (md.op == MD_DIV || md.op == MD_DIVU)
                              ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                    state_d   = ST_RUN;
                end else if (md.start && md.op == MD_MTHI) begin
                    hi_d = md.d1;
                end else if (md.start && md.op == MD_MTLO) begin
                    lo_d = md.d1;
                end
            end
            // Any start seen here is a stall violation and is ignored, so a
            // completing commit always wins over a late MTHI/MTLO.
            ST_RUN: begin
                if (cnt_q == '0) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset; reset discards any pending result.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q == ST_RUN) || issue_mc;
    assign md.busy  = busy;
    assign md.stall = md.d_uses_md && busy;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
    assign md.done  = done_q;

endmodule
